regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/rv_pkg.sv | 11 +
 rtl/regfile_sb_board.sv | 47 ++++
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file configuration: default widths and the register address type.
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREG_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT   = $clog2(NREG_DEFAULT);

  // Register index for the default configuration (x0..x31).
  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_board.sv
// Pending-producer scoreboard: one busy bit per architectural register.
// Priority on a single edge: flush > set (issue) > clear (writeback).
// Bit 0 is tied to zero because x0 never has a pending producer.
module regfile_sb_board #(
  parameter int unsigned NREG = 32,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_i,
  input  logic [AW-1:0]   set_idx_i,
  input  logic            clr_i,
  input  logic [AW-1:0]   clr_idx_i,
  input  logic            flush_i,
  output logic [NREG-1:0] busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector: clear on writeback, then set on issue so set wins, flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) begin
      busy_d[clr_idx_i] = 1'b0;
    end
    if (set_i && (set_idx_i != '0)) begin
      busy_d[set_idx_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Busy bits are cleared asynchronously by reset and updated on every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-through reads and an issue scoreboard.
// Issue handshake: issue_v is a request held by the issuing stage; issue_ready
// is the same-cycle grant, and an instruction is issued exactly on an edge where
// issue_v && issue_ready. issue_ready never depends on a registered grant, so a
// request that is not granted simply stays asserted until a later cycle.
module regfile_sb
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned NREG = NREG_DEFAULT,
  parameter int unsigned NRP  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRP*AW-1:0]   ra,
  input  logic [NRP-1:0]      ra_use,
  output logic [NRP*XLEN-1:0] rd,
  input  logic                we,
  input  logic [AW-1:0]       rc,
  input  logic [XLEN-1:0]     wd,
  input  logic                issue_v,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  output logic [NRP-1:0]      rs_busy,
  input  logic                flush
);

  logic [XLEN-1:0] x_q [NREG];
  logic [NREG-1:0] busy;
  logic            wr_en;
  logic            waw_block;

  // x0 is hardwired zero, so a write addressed to it is dropped here.
  assign wr_en = we && (rc != '0);

  // Register storage: asynchronous clear, one write per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        x_q[r] <= '0;
      end
    end else if (wr_en) begin
      x_q[rc] <= wd;
    end
  end

  // Per-port read data with write-through, and per-port hazard flag.
  for (genvar i = 0; i < NRP; i++) begin : g_port
    logic [AW-1:0] addr;
    logic          wb_hit;
    assign addr   = ra[i*AW +: AW];
    assign wb_hit = we && (rc == addr);

    // Outputs are forced to zero while reset is asserted.
    always_comb begin
      if (!rst_n || (addr == '0)) begin
        rd[i*XLEN +: XLEN] = '0;
      end else if (wb_hit) begin
        rd[i*XLEN +: XLEN] = wd;
      end else begin
        rd[i*XLEN +: XLEN] = x_q[addr];
      end
      rs_busy[i] = rst_n && ra_use[i] && busy[addr] && !wb_hit;
    end
  end

  // A destination with a pending producer blocks issue unless it is written back this cycle.
  assign waw_block   = (issue_rd != '0) && busy[issue_rd] && !(we && (rc == issue_rd));
  assign issue_ready = rst_n && issue_v && !flush && !(|rs_busy) && !waw_block;

  regfile_sb_board #(
    .NREG (NREG)
  ) u_board (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_i     (issue_ready),
    .set_idx_i (issue_rd),
    .clr_i     (we),
    .clr_idx_i (rc),
    .flush_i   (flush),
    .busy_o    (busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  import rv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT A: default build ----------------
  logic            rst_n_a;
  reg_addr_t       ra0_a, ra1_a;
  logic [1:0]      use_a;
  logic [63:0]     rd_a;
  logic            we_a;
  reg_addr_t       rc_a;
  logic [31:0]     wd_a;
  logic            iv_a;
  reg_addr_t       ird_a;
  logic            ir_a;
  logic [1:0]      rsb_a;
  logic            fl_a;

  regfile_sb u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .ra({ra1_a, ra0_a}), .ra_use(use_a), .rd(rd_a),
    .we(we_a), .rc(rc_a), .wd(wd_a), .issue_v(iv_a), .issue_rd(ird_a),
    .issue_ready(ir_a), .rs_busy(rsb_a), .flush(fl_a)
  );

  // ---------------- DUT B: NRP=3, XLEN=64, NREG=16 ----------------
  logic            rst_n_b;
  logic [3:0]      rab [3];
  logic [2:0]      use_b;
  logic [191:0]    rd_b;
  logic            we_b;
  logic [3:0]      rc_b;
  logic [63:0]     wd_b;
  logic            iv_b;
  logic [3:0]      ird_b;
  logic            ir_b;
  logic [2:0]      rsb_b;
  logic            fl_b;

  regfile_sb #(.XLEN(64), .NREG(16), .NRP(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .ra({rab[2], rab[1], rab[0]}), .ra_use(use_b), .rd(rd_b),
    .we(we_b), .rc(rc_b), .wd(wd_b), .issue_v(iv_b), .issue_rd(ird_b),
    .issue_ready(ir_b), .rs_busy(rsb_b), .flush(fl_b)
  );

  // ---------------- reference model (architectural view) ----------------
  logic [31:0] mx [32];
  bit   [31:0] mbusy;
  logic [63:0] bx [16];

  function automatic logic [31:0] exp_read(reg_addr_t a);
    if (!rst_n_a || a == 0) return 32'h0;
    if (we_a && rc_a == a)  return wd_a;
    return mx[a];
  endfunction

  function automatic logic exp_hazard(reg_addr_t a, logic u);
    return rst_n_a && u && mbusy[a] && !(we_a && rc_a == a);
  endfunction

  function automatic logic exp_ready();
    logic [1:0] hz;
    hz[0] = exp_hazard(ra0_a, use_a[0]);
    hz[1] = exp_hazard(ra1_a, use_a[1]);
    if (!rst_n_a || !iv_a || fl_a || hz != 2'b00) return 1'b0;
    if (ird_a != 0 && mbusy[ird_a] && !(we_a && rc_a == ird_a)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset_a();
    for (int r = 0; r < 32; r++) mx[r] = '0;
    mbusy = '0;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic a_idle();
    ra0_a = 0; ra1_a = 0; use_a = 0; we_a = 0; rc_a = 0; wd_a = 0;
    iv_a = 0; ird_a = 0; fl_a = 0;
  endtask

  task automatic b_idle();
    rab[0] = 0; rab[1] = 0; rab[2] = 0; use_b = 0; we_b = 0; rc_b = 0; wd_b = 0;
    iv_b = 0; ird_b = 0; fl_b = 0;
  endtask

  // Compare every combinational output of DUT A against the model.
  task automatic a_eval(input string tag);
    #1;
    check_eq({tag, "_rd0"}, {32'h0, rd_a[31:0]},  {32'h0, exp_read(ra0_a)});
    check_eq({tag, "_rd1"}, {32'h0, rd_a[63:32]}, {32'h0, exp_read(ra1_a)});
    check_eq({tag, "_rsb"}, {62'h0, rsb_a},
             {62'h0, exp_hazard(ra1_a, use_a[1]), exp_hazard(ra0_a, use_a[0])});
    check_eq({tag, "_ird"}, {63'h0, ir_a}, {63'h0, exp_ready()});
  endtask

  // Advance one edge and apply the architectural effect of the held inputs.
  task automatic a_clock();
    logic rdy;
    rdy = exp_ready();
    @(posedge clk); #1;
    if (we_a && rc_a != 0) mx[rc_a] = wd_a;
    if (fl_a) mbusy = '0;
    else begin
      if (we_a) mbusy[rc_a] = 1'b0;
      if (rdy && ird_a != 0) mbusy[ird_a] = 1'b1;
    end
    mbusy[0] = 1'b0;
  endtask

  task automatic a_cycle(input string tag);
    a_eval(tag);
    a_clock();
  endtask

  task automatic b_clock();
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0, r1, r2;
    a_idle(); b_idle();
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    model_reset_a();
    for (int r = 0; r < 16; r++) bx[r] = '0;

    // Reset holds outputs low even with active inputs.
    @(posedge clk); #1;
    we_a = 1; rc_a = 5; wd_a = 32'h1111_2222; ra0_a = 5; ra1_a = 5; use_a = 2'b11;
    iv_a = 1; ird_a = 4;
    #1;
    check_eq("rst_rd",  rd_a, 64'h0);
    check_eq("rst_rsb", {62'h0, rsb_a}, 64'h0);
    check_eq("rst_ird", {63'h0, ir_a}, 64'h0);
    @(posedge clk); #3;
    a_idle();
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(posedge clk); #1;
    a_eval("post_rst");

    // Write-through to x5, then the stored value.
    we_a = 1; rc_a = 5; wd_a = 32'hDEAD_BEEF; ra0_a = 5;
    #1; check_eq("wt_x5", {32'h0, rd_a[31:0]}, 64'hDEAD_BEEF);
    a_cycle("wt");
    a_idle(); ra0_a = 5;
    #1; check_eq("hold_x5", {32'h0, rd_a[31:0]}, 64'hDEAD_BEEF);
    a_cycle("hold");

    // Writes to x0 are discarded and x0 never goes busy.
    we_a = 1; rc_a = 0; wd_a = 32'h1234; ra1_a = 0;
    #1; check_eq("x0_wt", {32'h0, rd_a[63:32]}, 64'h0);
    a_cycle("x0w");
    a_idle(); iv_a = 1; ird_a = 0;
    a_cycle("x0iss");
    a_idle(); use_a = 2'b11;
    #1; check_eq("x0_busy", {62'h0, rsb_a}, 64'h0);
    check_eq("x0_rd", rd_a, 64'h0);
    a_cycle("x0chk");

    // RAW hazard on x7, resolved by same-cycle writeback.
    a_idle(); iv_a = 1; ird_a = 7;
    a_cycle("iss7");
    iv_a = 1; ird_a = 8; ra0_a = 7; use_a = 2'b01;
    #1; check_eq("raw7_busy", {63'h0, rsb_a[0]}, 64'h1);
    check_eq("raw7_stall", {63'h0, ir_a}, 64'h0);
    a_cycle("raw7");
    we_a = 1; rc_a = 7; wd_a = 32'h0000_0777;
    #1; check_eq("raw7_wb", {63'h0, rsb_a[0]}, 64'h0);
    check_eq("raw7_go", {63'h0, ir_a}, 64'h1);
    a_cycle("wb7");

    // Set beats clear on x9, then flush clears everything but keeps data.
    a_idle(); iv_a = 1; ird_a = 9; we_a = 1; rc_a = 9; wd_a = 32'h0000_0999;
    a_cycle("setclr9");
    a_idle(); ra0_a = 9; use_a = 2'b01;
    #1; check_eq("x9_busy", {63'h0, rsb_a[0]}, 64'h1);
    a_cycle("x9b");
    a_idle(); fl_a = 1; iv_a = 1; ird_a = 10;
    #1; check_eq("flush_nogo", {63'h0, ir_a}, 64'h0);
    a_cycle("flush");
    a_idle(); ra0_a = 9; ra1_a = 8; use_a = 2'b11;
    #1; check_eq("flush_rsb", {62'h0, rsb_a}, 64'h0);
    check_eq("flush_x9", {32'h0, rd_a[31:0]}, 64'h999);
    a_cycle("postfl");

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      ra0_a = reg_addr_t'($urandom_range(0, 31));
      ra1_a = ($urandom_range(0, 3) == 0) ? ra0_a : reg_addr_t'($urandom_range(0, 31));
      use_a = 2'($urandom_range(0, 3));
      we_a  = 1'($urandom_range(0, 1));
      rc_a  = ($urandom_range(0, 2) == 0) ? ra0_a : reg_addr_t'($urandom_range(0, 31));
      wd_a  = $urandom;
      iv_a  = 1'($urandom_range(0, 1));
      ird_a = reg_addr_t'($urandom_range(0, 31));
      fl_a  = ($urandom_range(0, 15) == 0);
      a_cycle("rnd");
    end

    // Asynchronous reset mid-cycle clears data and hazards without a clock edge.
    a_idle(); we_a = 1; rc_a = 3; wd_a = 32'hA5A5_A5A5;
    a_cycle("w3");
    a_idle(); iv_a = 1; ird_a = 3;
    a_cycle("iss3");
    a_idle(); ra0_a = 3; use_a = 2'b01;
    #1; check_eq("x3_pre", {32'h0, rd_a[31:0]}, 64'hA5A5_A5A5);
    check_eq("x3_busy_pre", {63'h0, rsb_a[0]}, 64'h1);
    #1; rst_n_a = 1'b0;
    #1; check_eq("arst_rd", {32'h0, rd_a[31:0]}, 64'h0);
    check_eq("arst_rsb", {62'h0, rsb_a}, 64'h0);
    model_reset_a();
    #1; rst_n_a = 1'b1;
    #1; check_eq("arst_x3", {32'h0, rd_a[31:0]}, 64'h0);
    check_eq("arst_busy", {62'h0, rsb_a}, 64'h0);
    @(posedge clk); #1;
    a_eval("rel");

    // DUT B: fill registers, read three distinct ones per cycle.
    for (int r = 1; r < 16; r++) begin
      we_b = 1; rc_b = 4'(r); wd_b = {$urandom, $urandom}; bx[r] = wd_b;
      b_clock();
    end
    b_idle();
    for (int n = 0; n < 10; n++) begin
      r0 = $urandom_range(1, 15); r1 = (r0 % 15) + 1; r2 = (r1 % 15) + 1;
      rab[0] = 4'(r0); rab[1] = 4'(r1); rab[2] = 4'(r2);
      #1;
      check_eq("b_rd0", rd_b[63:0],    bx[r0]);
      check_eq("b_rd1", rd_b[127:64],  bx[r1]);
      check_eq("b_rd2", rd_b[191:128], bx[r2]);
      b_clock();
    end
    rab[0] = 6; rab[1] = 6; rab[2] = 0;
    #1; check_eq("b_same", rd_b[127:64], rd_b[63:0] === bx[6] ? bx[6] : ~bx[6]);
    check_eq("b_r0", rd_b[191:128], 64'h0);

    // DUT B: WAW on x15 holds until writeback.
    b_idle(); iv_b = 1; ird_b = 15;
    #1; check_eq("b_iss15", {63'h0, ir_b}, 64'h1);
    b_clock();
    for (int n = 0; n < 3; n++) begin
      #1; check_eq("b_waw", {63'h0, ir_b}, 64'h0);
      b_clock();
    end
    we_b = 1; rc_b = 15; wd_b = 64'h0123_4567_89AB_CDEF;
    #1; check_eq("b_waw_wb", {63'h0, ir_b}, 64'h1);
    b_clock();
    we_b = 0; rab[0] = 15; use_b = 3'b001;
    #1; check_eq("b_reissue", {63'h0, ir_b}, 64'h0);
    check_eq("b_rsb15", {61'h0, rsb_b}, 64'h1);
    check_eq("b_x15", rd_b[63:0], 64'h0123_4567_89AB_CDEF);
    b_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
